eth_pkt_sched: RTL and testbench

ETH_PKT_SCHED -- requirements
Module: eth_pkt_sched

---
 rtl/eth_pkt_sched.sv | 131 +++++++++++++
 tb/tb_eth_pkt_sched.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_pkt_sched.sv
// Camera/status UDP packet scheduler: alternating-priority grant, frame/packet bookkeeping, IFG.
// Define ETH_SCHED_WDOG_EN to add the send_end watchdog and the sticky tmo_err output.
`timescale 1ns/1ps
module eth_pkt_sched #(
  parameter int unsigned PKT_BYTES  = 1280,
  parameter int unsigned CAM_THRESH = 320,
  parameter int unsigned STAT_BYTES = 16,
  parameter int unsigned GAP_CYC    = 24,
  parameter int unsigned TMO_CYC    = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  cam_used,
  input  logic        frame_start,
  input  logic        stat_req,
  output logic        stat_grant,
  output logic        send_en,
  output logic [15:0] send_data_num,
  output logic        src_sel,
  input  logic        read_data_req,
  input  logic        send_end,
  output logic        cam_rdreq,
  output logic        stat_rdreq,
  output logic [15:0] frame_id,
  output logic [15:0] pkt_idx,
`ifdef ETH_SCHED_WDOG_EN
  output logic        tmo_err,
`endif
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;

  localparam int unsigned GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  state_t        state, state_nxt;
  logic [GW-1:0] gap_cnt;
  logic          last_src;
  logic          frame_pend;
  logic          cam_ok;
  logic          stat_win;
  logic          grant_stat;
  logic          grant_cam;
  logic          wait_exit;
  logic          tmo_hit;

`ifdef ETH_SCHED_WDOG_EN
  localparam int unsigned TW = $clog2(TMO_CYC + 1);
  logic [TW-1:0] wd_cnt;

  assign tmo_hit = (state == WAIT) && !send_end && (wd_cnt == TW'(TMO_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt  <= '0;
      tmo_err <= 1'b0;
    end else begin
      wd_cnt <= (state == WAIT && !wait_exit) ? wd_cnt + 1'b1 : '0;
      if (tmo_hit) tmo_err <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    cam_ok     = 32'(cam_used) >= CAM_THRESH;
    stat_win   = stat_req && (!last_src || !cam_ok);
    grant_stat = (state == IDLE) && stat_win;
    grant_cam  = (state == IDLE) && cam_ok && !stat_win;
    wait_exit  = (state == WAIT) && (send_end || tmo_hit);
    state_nxt  = state;
    unique case (state)
      IDLE:    if (grant_stat || grant_cam) state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT:    if (wait_exit) state_nxt = GAP;
      GAP:     if (gap_cnt == GW'(GAP_CYC - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      send_en       <= 1'b0;
      stat_grant    <= 1'b0;
      src_sel       <= 1'b0;
      send_data_num <= '0;
      last_src      <= 1'b0;
      frame_pend    <= 1'b0;
      frame_id      <= '0;
      pkt_idx       <= '0;
      gap_cnt       <= '0;
    end else begin
      send_en    <= (state == START);
      stat_grant <= grant_stat;
      if (grant_stat || grant_cam) begin
        src_sel       <= grant_stat;
        last_src      <= grant_stat;
        send_data_num <= grant_stat ? 16'(STAT_BYTES) : 16'(PKT_BYTES);
      end
      gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
      // A frame boundary seen mid-packet is deferred to the WAIT exit and replaces that packet's index bump
      if (wait_exit) begin
        if (frame_pend || frame_start) begin
          frame_id   <= frame_id + 1'b1;
          pkt_idx    <= '0;
          frame_pend <= 1'b0;
        end else if (!src_sel && !tmo_hit) begin
          pkt_idx <= pkt_idx + 1'b1;
        end
      end else if (frame_start) begin
        if (state == START || state == WAIT) begin
          frame_pend <= 1'b1;
        end else begin
          frame_id <= frame_id + 1'b1;
          pkt_idx  <= '0;
        end
      end
    end
  end

  assign cam_rdreq  = read_data_req && !src_sel && (state == WAIT);
  assign stat_rdreq = read_data_req &&  src_sel && (state == WAIT);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_eth_pkt_sched.sv
// Randomized self-checking bench for eth_pkt_sched; acts as the UDP transmitter and tracks a packet-level model.
// Build with ETH_SCHED_WDOG_EN defined to also exercise the send_end watchdog.
`timescale 1ns/1ps
module tb_eth_pkt_sched;

  localparam int unsigned PKT_BYTES  = 1280;
  localparam int unsigned CAM_THRESH = 320;
  localparam int unsigned STAT_BYTES = 16;
  localparam int unsigned GAP_CYC    = 24;
  localparam int unsigned TMO_CYC    = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  cam_used;
  logic        frame_start;
  logic        stat_req;
  logic        stat_grant;
  logic        send_en;
  logic [15:0] send_data_num;
  logic        src_sel;
  logic        read_data_req;
  logic        send_end;
  logic        cam_rdreq;
  logic        stat_rdreq;
  logic [15:0] frame_id;
  logic [15:0] pkt_idx;
  logic        busy;
`ifdef ETH_SCHED_WDOG_EN
  logic        tmo_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // packet-level reference state
  bit          m_last_src;
  logic [15:0] m_frame_id;
  logic [15:0] m_pkt_idx;
  bit          m_pend;
  bit          g_idle;
  int          g_tend;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  eth_pkt_sched #(
    .PKT_BYTES (PKT_BYTES),
    .CAM_THRESH(CAM_THRESH),
    .STAT_BYTES(STAT_BYTES),
    .GAP_CYC   (GAP_CYC),
    .TMO_CYC   (TMO_CYC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cam_used     (cam_used),
    .frame_start  (frame_start),
    .stat_req     (stat_req),
    .stat_grant   (stat_grant),
    .send_en      (send_en),
    .send_data_num(send_data_num),
    .src_sel      (src_sel),
    .read_data_req(read_data_req),
    .send_end     (send_end),
    .cam_rdreq    (cam_rdreq),
    .stat_rdreq   (stat_rdreq),
    .frame_id     (frame_id),
    .pkt_idx      (pkt_idx),
`ifdef ETH_SCHED_WDOG_EN
    .tmo_err      (tmo_err),
`endif
    .busy         (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Status takes the turn when both are ready and the camera went last; otherwise whoever is ready.
  function automatic bit pick_stat(input logic [9:0] cu, input bit sr);
    bit cam_rdy;
    cam_rdy = int'(cu) >= int'(CAM_THRESH);
    if (cam_rdy && sr) return (m_last_src == 1'b0);
    return sr;
  endfunction

  task automatic do_reset;
    rst = 1'b1; cam_used = '0; stat_req = 1'b0; frame_start = 1'b0;
    read_data_req = 1'b1; send_end = 1'b0;
    tick;
    check_eq("rst_send_en",    32'(send_en),       32'd0);
    check_eq("rst_stat_grant", 32'(stat_grant),    32'd0);
    check_eq("rst_src_sel",    32'(src_sel),       32'd0);
    check_eq("rst_busy",       32'(busy),          32'd0);
    check_eq("rst_len",        32'(send_data_num), 32'd0);
    check_eq("rst_frame_id",   32'(frame_id),      32'd0);
    check_eq("rst_pkt_idx",    32'(pkt_idx),       32'd0);
    check_eq("rst_cam_rdreq",  32'(cam_rdreq),     32'd0);
    check_eq("rst_stat_rdreq", 32'(stat_rdreq),    32'd0);
`ifdef ETH_SCHED_WDOG_EN
    check_eq("rst_tmo_err",    32'(tmo_err),       32'd0);
`endif
    tick;
    rst = 1'b0; read_data_req = 1'b0;
    m_last_src = 1'b0; m_frame_id = '0; m_pkt_idx = '0; m_pend = 1'b0;
    g_idle = 1'b1;
  endtask

  // One full packet as seen by the transmitter; cu/sr apply only when starting from idle.
  task automatic do_packet(input logic [9:0] cu, input bit sr, input int wait_len, input int fs_wait_n,
                           input bit fs_end, input bit fs_gap, input logic [9:0] ncu, input bit nsr);
    bit          exp_stat, got_se, prev_sg, rd;
    int          sg_seen, t_start, lat;
    logic [15:0] exp_len;
    if (g_idle) begin
      cam_used = cu; stat_req = sr;
    end
    exp_stat = pick_stat(cam_used, stat_req);
    exp_len  = exp_stat ? 16'(STAT_BYTES) : 16'(PKT_BYTES);
    t_start  = cyc;
    got_se = 1'b0; prev_sg = 1'b0; sg_seen = 0;
    for (int i = 0; i < 60 && !got_se; i++) begin
      tick;
      if (send_en) got_se = 1'b1;
      else begin
        prev_sg = stat_grant;
        sg_seen += int'(stat_grant);
      end
    end
    check_eq("send_en_arrives", 32'(got_se), 32'd1);
    if (!got_se) return;
    lat = cyc - (g_idle ? t_start : g_tend);
    if (g_idle) check_eq("req_to_send_en_latency", 32'(lat), 32'd2);
    else        check_eq("ifg_min_after_send_end", 32'(lat >= int'(GAP_CYC) + 1), 32'd1);
    check_eq("stat_grant_cycle_before_send_en", 32'(prev_sg), 32'(exp_stat));
    check_eq("stat_grant_pulse_count", 32'(sg_seen), 32'(exp_stat));
    check_eq("src_sel", 32'(src_sel), 32'(exp_stat));
    check_eq("send_data_num", 32'(send_data_num), 32'(exp_len));
    check_eq("busy_in_packet", 32'(busy), 32'd1);
    m_last_src = exp_stat;

    for (int i = 0; i < wait_len; i++) begin
      rd = 1'($urandom_range(0, 1));
      read_data_req = rd;
      frame_start = (fs_wait_n > 0 && i == 1) || (fs_wait_n > 1 && i == 3);
      if (frame_start) m_pend = 1'b1;
      #1;
      check_eq("cam_rdreq_wait",  32'(cam_rdreq),  32'(rd && !exp_stat));
      check_eq("stat_rdreq_wait", 32'(stat_rdreq), 32'(rd && exp_stat));
      tick;
      frame_start = 1'b0;
      check_eq("send_en_one_cycle", 32'(send_en),       32'd0);
      check_eq("src_sel_stable",    32'(src_sel),       32'(exp_stat));
      check_eq("len_stable",        32'(send_data_num), 32'(exp_len));
      check_eq("frame_id_deferred", 32'(frame_id),      32'(m_frame_id));
    end

    read_data_req = 1'b0; send_end = 1'b1; frame_start = fs_end;
    tick;
    send_end = 1'b0; frame_start = 1'b0;
    if (m_pend || fs_end) begin
      m_frame_id++; m_pkt_idx = '0; m_pend = 1'b0;
    end else if (!exp_stat) begin
      m_pkt_idx++;
    end
    check_eq("frame_id_after_pkt", 32'(frame_id), 32'(m_frame_id));
    check_eq("pkt_idx_after_pkt",  32'(pkt_idx),  32'(m_pkt_idx));
    g_tend = cyc;
    cam_used = ncu; stat_req = nsr;

    for (int i = 0; i < 4; i++) begin
      read_data_req = 1'b1;
      frame_start = fs_gap && (i == 1);
      send_end = (i == 2);
      #1;
      check_eq("cam_rdreq_gap",  32'(cam_rdreq),  32'd0);
      check_eq("stat_rdreq_gap", 32'(stat_rdreq), 32'd0);
      check_eq("busy_gap",       32'(busy),       32'd1);
      tick;
      if (frame_start) begin
        m_frame_id++; m_pkt_idx = '0;
      end
      frame_start = 1'b0; send_end = 1'b0;
      check_eq("frame_id_gap", 32'(frame_id), 32'(m_frame_id));
      check_eq("pkt_idx_gap",  32'(pkt_idx),  32'(m_pkt_idx));
    end
    read_data_req = 1'b0;

    if (int'(ncu) < int'(CAM_THRESH) && !nsr) begin
      repeat (GAP_CYC) tick;
      check_eq("idle_after_gap",    32'(busy),    32'd0);
      check_eq("no_send_when_idle", 32'(send_en), 32'd0);
      g_idle = 1'b1;
    end else begin
      g_idle = 1'b0;
    end
  endtask

  task automatic idle_frame_start;
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    m_frame_id++; m_pkt_idx = '0;
    check_eq("idle_fs_frame_id", 32'(frame_id), 32'(m_frame_id));
    check_eq("idle_fs_pkt_idx",  32'(pkt_idx),  32'(m_pkt_idx));
    check_eq("idle_fs_busy",     32'(busy),     32'd0);
  endtask

  task automatic mid_wait_reset;
    do_reset;
    cam_used = 10'd500; stat_req = 1'b0;
    repeat (4) tick;
    check_eq("busy_before_abort", 32'(busy), 32'd1);
    do_reset;
    send_end = 1'b1;
    tick;
    send_end = 1'b0;
    repeat (3) tick;
    check_eq("late_end_busy",    32'(busy),    32'd0);
    check_eq("late_end_pkt_idx", 32'(pkt_idx), 32'd0);
    check_eq("late_end_send_en", 32'(send_en), 32'd0);
  endtask

`ifdef ETH_SCHED_WDOG_EN
  task automatic wdog_test;
    bit seen;
    int t0;
    cam_used = 10'd600; stat_req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick;
      seen = send_en;
    end
    check_eq("wdog_pkt_started", 32'(seen), 32'd1);
    cam_used = '0;
    m_last_src = 1'b0;
    t0 = cyc; seen = 1'b0;
    for (int i = 0; i < int'(TMO_CYC) + 50 && !seen; i++) begin
      tick;
      seen = tmo_err;
    end
    check_eq("tmo_err_set", 32'(seen), 32'd1);
    check_eq("tmo_not_early", 32'(cyc - t0 >= int'(TMO_CYC) - 1), 32'd1);
    check_eq("tmo_in_gap_busy", 32'(busy), 32'd1);
    check_eq("tmo_pkt_idx_kept", 32'(pkt_idx), 32'(m_pkt_idx));
    repeat (GAP_CYC + 4) tick;
    check_eq("tmo_back_to_idle", 32'(busy), 32'd0);
    g_idle = 1'b1;
    do_packet(10'd700, 1'b0, 5, 0, 1'b0, 1'b0, 10'd0, 1'b0);
    check_eq("tmo_err_sticky", 32'(tmo_err), 32'd1);
  endtask
`endif

  initial begin
    bit          bad, sr, nsr, fe, fg;
    logic [9:0]  cu, ncu;
    int          wl, fw;
    rst = 1'b1; cam_used = '0; stat_req = 1'b0; frame_start = 1'b0;
    read_data_req = 1'b0; send_end = 1'b0;
    do_reset;

    cam_used = 10'd319; stat_req = 1'b0; bad = 1'b0;
    repeat (10) begin
      tick;
      if (send_en || busy) bad = 1'b1;
    end
    check_eq("below_threshold_no_send", 32'(bad), 32'd0);

    do_packet(10'd320, 1'b0, 6, 0, 1'b0, 1'b0, 10'd0,   1'b1);
    do_packet(10'd0,   1'b0, 5, 0, 1'b0, 1'b0, 10'd400, 1'b1);
    do_packet(10'd0,   1'b0, 5, 0, 1'b0, 1'b0, 10'd400, 1'b1);
    do_packet(10'd0,   1'b0, 5, 0, 1'b0, 1'b0, 10'd400, 1'b1);
    do_packet(10'd0,   1'b0, 5, 0, 1'b0, 1'b0, 10'd400, 1'b0);
    do_packet(10'd0,   1'b0, 5, 0, 1'b0, 1'b0, 10'd400, 1'b0);
    do_packet(10'd0,   1'b0, 5, 0, 1'b0, 1'b0, 10'd0,   1'b0);
    check_eq("pkt_idx_reached_5", 32'(pkt_idx), 32'd5);
    do_packet(10'd400, 1'b0, 6, 1, 1'b0, 1'b0, 10'd0,   1'b0);
    idle_frame_start;
    do_packet(10'd500, 1'b0, 6, 2, 1'b0, 1'b0, 10'd500, 1'b0);
    do_packet(10'd0,   1'b0, 6, 0, 1'b1, 1'b1, 10'd0,   1'b0);

    for (int n = 0; n < 30; n++) begin
      cu  = 10'($urandom_range(0, 1023));
      sr  = 1'($urandom_range(0, 1));
      if (g_idle && int'(cu) < int'(CAM_THRESH)) sr = 1'b1;
      ncu = 10'($urandom_range(0, 1023));
      nsr = 1'($urandom_range(0, 1));
      wl  = $urandom_range(4, 16);
      fw  = $urandom_range(0, 5);
      if (fw > 2) fw = 0;
      fe  = ($urandom_range(0, 7) == 0);
      fg  = ($urandom_range(0, 7) == 0);
      if (g_idle && $urandom_range(0, 3) == 0) idle_frame_start;
      do_packet(cu, sr, wl, fw, fe, fg, ncu, nsr);
    end

    mid_wait_reset;
    do_packet(10'd400, 1'b1, 5, 0, 1'b0, 1'b0, 10'd400, 1'b1);
    do_packet(10'd0,   1'b0, 5, 0, 1'b0, 1'b0, 10'd0,   1'b0);

`ifdef ETH_SCHED_WDOG_EN
    wdog_test;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation still running at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
